pwm_channel_bank: RTL and testbench
===================================

# pwm_channel_bank

Multi-channel PWM generator with an internal period counter, double-buffered period and compare registers, per-channel enable and polarity, and working rise/fall event pulses. It sits in the PWM peripheral behind the register interface: the bus-side logic drives the configuration inputs, and the event pulses feed the peripheral interrupt logic. All channels share one counter, so their outputs are phase-aligned.

## Interface
- WIDTH, 16, counter/compare/top width (≥2)
- CHANNELS, 4, number of PWM channels (1–16)
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- enable  in  1  counter run; 0 = held stopped
- top  in  WIDTH  period top value (live; shadowed)
- compare  in  CHANNELS*WIDTH  channel i compare at [i*WIDTH +: WIDTH] (live; shadowed)
- channelEnable  in  CHANNELS  per-channel output enable
- invert  in  CHANNELS  per-channel output polarity
- centerAlign  in  1  up/down mode select (used only with PWM_CENTER_ALIGN_EN)
- counterValue  out  WIDTH  current counter
- periodStart  out  1  high while enable=1 and counterValue==0
- pwm_out  out  CHANNELS  PWM outputs
- compareRise  out  CHANNELS  one-cycle pulse on rising edge of the un-inverted channel state
- compareFall  out  CHANNELS  one-cycle pulse on falling edge of the un-inverted channel state

## Operation
- Reset values: counter, direction, all shadows, channel states, lastState, compareRise and compareFall are 0. pwm_out = invert after reset.
- Disabled (enable=0):
  - counter forced to 0, direction set to up;
  - topShadow and every compareShadow reload from the live inputs every cycle;
  - all channel states forced to 0.
- Edge mode, enabled: counter <= (counter==topShadow) ? 0 : counter+1. Period = topShadow+1 cycles.
- Shadow reload, enabled: occurs only on the cycle the counter transitions to 0. Live-input changes mid-period take effect at the next period.
- Channel state: state_i <= enable & channelEnable[i] & (counter < compareShadow_i).
  - compareShadow=0 gives constant low (0%).
  - compareShadow>topShadow gives constant high (100%).
- pwm_out[i] = state_i ^ invert[i]. invert is live, not shadowed.
- Events: lastState <= state. compareRise = registered (state & ~lastState); compareFall = registered (~state & lastState). Inversion does not affect which pulse fires.
- Compare arithmetic: unsigned, WIDTH bits, no wrap in the compare itself.
- top=0, edge mode: counter stays 0 and shadows reload every cycle.

## Timing
- The state register updates one cycle after counterValue.
- pwm_out is registered state, so it lags counterValue by 1 cycle.
- compareRise/compareFall lag the pwm_out edge by 1 cycle and last exactly 1 cycle.
- Disable mid-period: counter is 0 on the next edge, states are 0 on the next edge, and a compareFall pulse follows for each channel that was high.
- enable and rst asserted together: rst wins.
- rst mid-operation: all registers hold their reset values after the next clk edge.

## Configuration
- PWM_CENTER_ALIGN_EN defined: when centerAlign=1 the counter counts 0→topShadow, then topShadow→0.
  - Direction flips on reaching topShadow (→down) and on reaching 0 (→up).
  - Each endpoint value is held for one cycle. Period = 2·topShadow cycles.
  - Shadows reload only on the transition to 0.
  - The output is high while counter < compareShadow, giving a pulse symmetric about 0.
  - top=0: counter stays 0.
  - Changing centerAlign while enabled takes effect at the next 0.
- PWM_CENTER_ALIGN_EN undefined: centerAlign is ignored, there is no direction register, and the mode is edge-only.

## Structure
- Package pwm_pkg holds the default WIDTH/CHANNELS constants and the counter direction encoding (DIR_UP=0, DIR_DOWN=1).
- Sub-module pwm_channel is generated CHANNELS times. Each instance holds its compare shadow, state, lastState and rise/fall registers. The counter, top shadow and direction live in the top level.

## Test plan
- Edge mode, top=9, compare[0]=3, enable=1 → counterValue cycles 0..9; pwm_out[0] high for 3 of every 10 cycles; compareRise[0] and compareFall[0] each pulse once per period, 1 cycle wide.
- compare[1]=0 and compare[2]=12 with top=9 → pwm_out[1] constant 0, pwm_out[2] constant 1; no event pulses after the first period.
- Change compare[0] from 3 to 7 at counterValue=5 → current period keeps a 3-cycle high, next period is 7 cycles high.
- invert[0]=1, compare=3 → pwm_out[0] low for 3 cycles per period; compareRise timing identical to invert=0.
- Deassert enable at counterValue=1 with compare=3 → next cycle counterValue=0 and pwm_out[0]=0, followed by one compareFall[0] pulse; assert rst mid-period → all outputs at reset values after 1 edge.
- With PWM_CENTER_ALIGN_EN, centerAlign=1, top=4, compare=2 → counterValue sequence 0,1,2,3,4,3,2,1,0 (8-cycle period); pwm_out high for 3 cycles centred on counter 0.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared constants for the PWM channel bank: default sizing and the
// up/down counter direction encoding used by the center-aligned mode.
package pwm_pkg;

  localparam int DEFAULT_WIDTH    = 16;
  localparam int DEFAULT_CHANNELS = 4;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: compare shadow, registered channel state, and the
// rise/fall event pulses derived from the un-inverted state.
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] compare,
  input  logic             channel_enable,
  input  logic             invert,
  input  logic [WIDTH-1:0] counter,
  output logic             pwm_out,
  output logic             rise,
  output logic             fall
);

  logic [WIDTH-1:0] compare_shadow;
  logic             state;
  logic             last_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      compare_shadow <= '0;
      state          <= 1'b0;
      last_state     <= 1'b0;
      rise           <= 1'b0;
      fall           <= 1'b0;
    end else begin
      if (load) compare_shadow <= compare;
      state      <= enable & channel_enable & (counter < compare_shadow);
      last_state <= state;
      rise       <= state & ~last_state;
      fall       <= ~state & last_state;
    end
  end

  // Polarity is applied after the state register so it takes effect immediately.
  assign pwm_out = state ^ invert;

endmodule

// File: rtl/pwm_channel_bank.sv
// Multi-channel PWM with one shared period counter and shadowed top/compare.
// Define PWM_CENTER_ALIGN_EN to add the up/down (center-aligned) counting mode.
module pwm_channel_bank
  import pwm_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int CHANNELS = DEFAULT_CHANNELS
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic [WIDTH-1:0]          top,
  input  logic [CHANNELS*WIDTH-1:0] compare,
  input  logic [CHANNELS-1:0]       channelEnable,
  input  logic [CHANNELS-1:0]       invert,
  input  logic                      centerAlign,
  output logic [WIDTH-1:0]          counterValue,
  output logic                      periodStart,
  output logic [CHANNELS-1:0]       pwm_out,
  output logic [CHANNELS-1:0]       compareRise,
  output logic [CHANNELS-1:0]       compareFall
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] counter;
  logic [WIDTH-1:0] counter_next;
  logic [WIDTH-1:0] top_shadow;
  logic             load;

`ifdef PWM_CENTER_ALIGN_EN
  dir_t dir;
  dir_t dir_next;
  logic center_shadow;

  always_comb begin
    counter_next = counter;
    dir_next     = dir;
    if (center_shadow) begin
      if (dir == DIR_UP) begin
        if (counter >= top_shadow) begin
          counter_next = (counter == '0) ? '0 : counter - ONE;
          dir_next     = DIR_DOWN;
        end else begin
          counter_next = counter + ONE;
        end
      end else begin
        counter_next = (counter == '0) ? '0 : counter - ONE;
      end
      // Every arrival at 0 turns the count back upward.
      if (counter_next == '0) dir_next = DIR_UP;
    end else begin
      counter_next = (counter == top_shadow) ? '0 : counter + ONE;
      dir_next     = DIR_UP;
    end
  end
`else
  logic unused_center_align;
  assign unused_center_align = centerAlign;

  always_comb begin
    counter_next = (counter == top_shadow) ? '0 : counter + ONE;
  end
`endif

  // Shadows follow the live inputs while stopped and at each period boundary.
  assign load = ~enable | (counter_next == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      counter    <= '0;
      top_shadow <= '0;
`ifdef PWM_CENTER_ALIGN_EN
      dir           <= DIR_UP;
      center_shadow <= 1'b0;
`endif
    end else begin
      counter <= enable ? counter_next : '0;
      if (load) top_shadow <= top;
`ifdef PWM_CENTER_ALIGN_EN
      dir <= enable ? dir_next : DIR_UP;
      if (load) center_shadow <= centerAlign;
`endif
    end
  end

  assign counterValue = counter;
  assign periodStart  = enable & (counter == '0);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    pwm_channel #(.WIDTH(WIDTH)) u_ch (
      .clk           (clk),
      .rst           (rst),
      .enable        (enable),
      .load          (load),
      .compare       (compare[i*WIDTH +: WIDTH]),
      .channel_enable(channelEnable[i]),
      .invert        (invert[i]),
      .counter       (counter),
      .pwm_out       (pwm_out[i]),
      .rise          (compareRise[i]),
      .fall          (compareFall[i])
    );
  end

endmodule

// File: tb/tb_pwm_channel_bank.sv
// Scoreboard bench for pwm_channel_bank: a phase-based period model predicts
// every cycle's outputs, a negedge monitor pops and compares them.
module tb_pwm_channel_bank;

  localparam int WIDTH = 16;
  localparam int CH    = 4;
  localparam int EW    = WIDTH + 1 + 3 * CH;

  // ---------------- clock / reset / DUT ----------------
  logic                clk = 1'b0;
  logic                rst;
  logic                enable;
  logic [WIDTH-1:0]    top;
  logic [CH*WIDTH-1:0] compare;
  logic [CH-1:0]       channelEnable;
  logic [CH-1:0]       invert;
  logic                centerAlign;
  logic [WIDTH-1:0]    counterValue;
  logic                periodStart;
  logic [CH-1:0]       pwm_out;
  logic [CH-1:0]       compareRise;
  logic [CH-1:0]       compareFall;

  always #5 clk = ~clk;

  pwm_channel_bank #(.WIDTH(WIDTH), .CHANNELS(CH)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .top          (top),
    .compare      (compare),
    .channelEnable(channelEnable),
    .invert       (invert),
    .centerAlign  (centerAlign),
    .counterValue (counterValue),
    .periodStart  (periodStart),
    .pwm_out      (pwm_out),
    .compareRise  (compareRise),
    .compareFall  (compareFall)
  );

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_e;
  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- reference model ----------------
  // The counter is modelled as a position within the current period.
  int m_phase;
  int m_top;
  int m_cmp[CH];
  bit m_center;
  bit m_st[CH];
  bit m_st_prev[CH];
  bit m_rise[CH];
  bit m_fall[CH];

  function automatic int m_count();
    if (m_center && m_phase > m_top) return 2 * m_top - m_phase;
    return m_phase;
  endfunction

  function automatic int m_period();
    if (m_center) return (m_top == 0) ? 1 : 2 * m_top;
    return m_top + 1;
  endfunction

  task automatic m_reload();
    m_top = int'(top);
    for (int i = 0; i < CH; i++) m_cmp[i] = int'(compare[i*WIDTH +: WIDTH]);
`ifdef PWM_CENTER_ALIGN_EN
    m_center = centerAlign;
`else
    m_center = 1'b0;
`endif
  endtask

  task automatic m_reset();
    m_phase  = 0;
    m_top    = 0;
    m_center = 1'b0;
    for (int i = 0; i < CH; i++) begin
      m_cmp[i] = 0; m_st[i] = 0; m_st_prev[i] = 0; m_rise[i] = 0; m_fall[i] = 0;
    end
  endtask

  function automatic logic [EW-1:0] m_expect();
    logic [CH-1:0] p, r, f;
    logic [WIDTH-1:0] c;
    logic ps;
    c  = WIDTH'(m_count());
    ps = enable && (m_count() == 0);
    for (int i = 0; i < CH; i++) begin
      p[i] = m_st[i] ^ invert[i];
      r[i] = m_rise[i];
      f[i] = m_fall[i];
    end
    return {c, ps, p, r, f};
  endfunction

  task automatic m_advance();
    int cnt;
    if (rst) begin
      m_reset();
    end else begin
      cnt = m_count();
      for (int i = 0; i < CH; i++) begin
        m_rise[i]    = m_st[i] & ~m_st_prev[i];
        m_fall[i]    = ~m_st[i] & m_st_prev[i];
        m_st_prev[i] = m_st[i];
        m_st[i]      = enable & channelEnable[i] & (cnt < m_cmp[i]);
      end
      if (!enable) begin
        m_phase = 0;
        m_reload();
      end else begin
        m_phase = (m_phase + 1) % m_period();
        if (m_phase == 0) m_reload();
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called at posedge+1 with inputs already applied for this cycle.
  task automatic cycle();
    exp_q.push_back(m_expect());
    m_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic set_cmp(input int i, input int v);
    compare[i*WIDTH +: WIDTH] = WIDTH'(v);
  endtask

  task automatic wait_count(input int v);
    int k;
    k = 0;
    while (m_count() != v && k < 100) begin
      cycle();
      k++;
    end
    if (m_count() != v) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_count: counter never reached %0d within 100 cycles", v);
    end
  endtask

  // ---------------- monitor ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("counterValue", 32'(counterValue), 32'(mon_e[EW-1 -: WIDTH]));
      check("periodStart",  32'(periodStart),  32'(mon_e[3*CH]));
      check("pwm_out",      32'(pwm_out),      32'(mon_e[3*CH-1 -: CH]));
      check("compareRise",  32'(compareRise),  32'(mon_e[2*CH-1 -: CH]));
      check("compareFall",  32'(compareFall),  32'(mon_e[CH-1:0]));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst           = 1'b1;
    enable        = 1'b0;
    top           = '0;
    compare       = '0;
    channelEnable = '0;
    invert        = CH'($urandom);
    centerAlign   = 1'b0;
    @(posedge clk);
    #1;
    m_reset();

    // Reset values, with rst overriding a simultaneous enable.
    for (int k = 0; k < 3; k++) begin
      invert = CH'($urandom);
      enable = (k == 2);
      cycle();
    end

    // Edge mode: top=9, 30% / 0% / 100% / 50% duty.
    rst = 1'b0;
    enable = 1'b1;
    invert = '0;
    channelEnable = '1;
    top = 16'd9;
    set_cmp(0, 3); set_cmp(1, 0); set_cmp(2, 12); set_cmp(3, 5);
    run(35);

    // Mid-period compare change applies from the next period.
    wait_count(5);
    set_cmp(0, 7);
    run(25);

    invert = 4'b0001;
    run(20);
    invert = '0;
    set_cmp(0, 3);
    run(12);

    // Disable mid-period, then reset mid-period.
    wait_count(1);
    enable = 1'b0;
    run(1);
    enable = 1'b1;
    run(15);
    wait_count(4);
    rst = 1'b1;
    run(2);
    rst = 1'b0;
    run(12);

    // top=0 keeps the counter at 0.
    top = '0;
    run(8);

`ifdef PWM_CENTER_ALIGN_EN
    centerAlign = 1'b1;
    top = 16'd4;
    set_cmp(0, 2);
    run(30);
    centerAlign = 1'b0;
    run(20);
`endif

    // Randomized configuration churn.
    for (int k = 0; k < 2000; k++) begin
      if ($urandom_range(0, 99) < 4) begin
        top = WIDTH'($urandom_range(0, 12));
        for (int i = 0; i < CH; i++)
          set_cmp(i, ($urandom_range(0, 9) == 0) ? 16'hFFFF : $urandom_range(0, 15));
        centerAlign = 1'($urandom_range(0, 1));
      end
      enable = ($urandom_range(0, 99) < 98);
      rst    = ($urandom_range(0, 999) < 5);
      if ($urandom_range(0, 99) < 5) invert = CH'($urandom);
      if ($urandom_range(0, 99) < 5) channelEnable = CH'($urandom);
      cycle();
    end

    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
